// File: rtl/prime_bench_pkg.sv
// Shared types, mode codes and the progress-bar step helper for prime_bench_ctrl.
package prime_bench_pkg;

  typedef logic [63:0] u64_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StHold,
    StWait,
    StDone,
    StErr
  } state_e;

  localparam logic [1:0] MODE_FREE  = 2'd0;
  localparam logic [1:0] MODE_COUNT = 2'd1;
  localparam logic [1:0] MODE_VALUE = 2'd2;

  // ceil((2^w - 1) / nleds): prime value covered by one LED
  function automatic u64_t calc_step(int unsigned w, int unsigned nleds);
    u64_t max_v;
    max_v = (u64_t'(1) << w) - u64_t'(1);
    return (max_v + u64_t'(nleds) - u64_t'(1)) / u64_t'(nleds);
  endfunction

endpackage

// File: rtl/progress_bar.sv
// Thermometer progress bar: lights one more LED each time value passes the next threshold.
module progress_bar
  import prime_bench_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned NLEDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [W-1:0]     value,
  output logic [NLEDS-1:0] leds
);

  localparam u64_t       STEP_FULL = calc_step(W, NLEDS);
  localparam logic [W:0] STEP      = STEP_FULL[W:0];

  // One extra bit so thr can pass MAX without wrapping back to small values
  logic [W:0] thr;

  // Advance at most one LED per cycle; stop once the bar is full
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      leds <= '0;
      thr  <= STEP;
    end else if (({1'b0, value} >= thr) && !(&leds)) begin
      leds <= (leds << 1) | NLEDS'(1);
      thr  <= thr + STEP;
    end
  end

endmodule

// File: rtl/prime_bench_ctrl.sv
// Drives a prime generator through go/ready/error, counting primes and busy cycles.
module prime_bench_ctrl
  import prime_bench_pkg::*;
#(
  parameter int unsigned WIDTH_LOG = 4,
  parameter int unsigned NLEDS     = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned CYC_W     = 32,
  localparam int unsigned W        = 1 << WIDTH_LOG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [W-1:0]     limit,
  output logic             pg_go,
  input  logic             pg_ready,
  input  logic             pg_error,
  input  logic [W-1:0]     pg_res,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] prime_cnt,
  output logic [W-1:0]     last_prime,
  output logic [CYC_W-1:0] cycles,
  output logic [NLEDS-1:0] leds
);

  state_e           state;
  logic [1:0]       mode_q;
  logic [W-1:0]     limit_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_limit;
  logic             stop_hit;
  logic             idle_like;

  // Saturating count and stop test, both evaluated against the about-to-be-accepted prime
  always_comb begin
    cnt_inc   = (&prime_cnt) ? prime_cnt : prime_cnt + CNT_W'(1);
    cnt_limit = CNT_W'(limit_q);
    idle_like = (state == StIdle) || (state == StDone) || (state == StErr);
    case (mode_q)
      MODE_COUNT: stop_hit = (cnt_inc >= cnt_limit);
      MODE_VALUE: stop_hit = (pg_res >= limit_q);
      default:    stop_hit = 1'b0;
    endcase
  end

  // Controller FSM with registered outputs and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      mode_q     <= '0;
      limit_q    <= '0;
      pg_go      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      prime_cnt  <= '0;
      last_prime <= '0;
      cycles     <= '0;
    end else begin
      if (busy && !(&cycles)) begin
        cycles <= cycles + CYC_W'(1);
      end
      case (state)
        StIdle, StDone, StErr: begin
          if (start) begin
            mode_q     <= mode;
            limit_q    <= limit;
            prime_cnt  <= '0;
            last_prime <= '0;
            cycles     <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b1;
            state      <= StIssue;
          end
        end
        StIssue: begin
          if (pg_ready) begin
            if (pg_error) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= StErr;
            end else begin
              pg_go <= 1'b1;
              state <= StHold;
            end
          end
        end
        // Ready from the previous result may still be high while go is being registered
        StHold: begin
          pg_go <= 1'b0;
          state <= StWait;
        end
        StWait: begin
          if (pg_ready) begin
            if (pg_error) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= StErr;
            end else begin
              last_prime <= pg_res;
              prime_cnt  <= cnt_inc;
              if (stop_hit) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= StDone;
              end else begin
                state <= StIssue;
              end
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  progress_bar #(
    .W    (W),
    .NLEDS(NLEDS)
  ) u_progress_bar (
    .clk  (clk),
    .rst  (rst),
    .clr  (start && idle_like),
    .value(last_prime),
    .leds (leds)
  );

endmodule

// File: tb/tb_prime_bench_ctrl.sv
// Bench: two controller instances (16-bit primes, and 4-bit primes with 4-bit cycle counter)
// each driving a behavioural prime generator.
module tb_prime_bench_ctrl;

  localparam int unsigned WA = 16;
  localparam int unsigned WB = 4;
  localparam int unsigned MAXA = 65535;
  localparam int unsigned MAXB = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A signals
  logic          start_a, go_a, rdy_a, gerr_a, busy_a, done_a, err_a, gen_clr_a;
  logic [1:0]    mode_a;
  logic [WA-1:0] limit_a, res_a, last_a;
  logic [15:0]   cnt_a;
  logic [31:0]   cyc_a;
  logic [3:0]    leds_a;
  // Instance B signals
  logic          start_b, go_b, rdy_b, gerr_b, busy_b, done_b, err_b, gen_clr_b;
  logic [1:0]    mode_b;
  logic [WB-1:0] limit_b, res_b, last_b;
  logic [15:0]   cnt_b;
  logic [3:0]    cyc_b;
  logic [3:0]    leds_b;

  prime_bench_ctrl #(.WIDTH_LOG(4), .NLEDS(4), .CNT_W(16), .CYC_W(32)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .limit(limit_a),
    .pg_go(go_a), .pg_ready(rdy_a), .pg_error(gerr_a), .pg_res(res_a),
    .busy(busy_a), .done(done_a), .err(err_a), .prime_cnt(cnt_a),
    .last_prime(last_a), .cycles(cyc_a), .leds(leds_a)
  );

  prime_bench_ctrl #(.WIDTH_LOG(2), .NLEDS(4), .CNT_W(16), .CYC_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .limit(limit_b),
    .pg_go(go_b), .pg_ready(rdy_b), .pg_error(gerr_b), .pg_res(res_b),
    .busy(busy_b), .done(done_b), .err(err_b), .prime_cnt(cnt_b),
    .last_prime(last_b), .cycles(cyc_b), .leds(leds_b)
  );

  function automatic bit is_prime(int unsigned n);
    if (n < 2) return 1'b0;
    for (int unsigned d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int unsigned next_prime(int unsigned x);
    int unsigned p;
    p = x + 1;
    while (!is_prime(p)) p++;
    return p;
  endfunction

  // Generator models: idle ready, result 3 cycles after go is seen, error once past MAX
  int unsigned gcnt_a = 0, gcnt_b = 0;
  always @(posedge clk) begin
    if (rst || gen_clr_a) begin
      rdy_a <= 1'b1; res_a <= '0; gerr_a <= 1'b0; gcnt_a <= 0;
    end else if (go_a) begin
      rdy_a <= 1'b0; gcnt_a <= 3;
    end else if (gcnt_a != 0) begin
      gcnt_a <= gcnt_a - 1;
      if (gcnt_a == 1) begin
        rdy_a <= 1'b1;
        if (next_prime(32'(res_a)) > MAXA) gerr_a <= 1'b1;
        else res_a <= 16'(next_prime(32'(res_a)));
      end
    end
  end

  always @(posedge clk) begin
    if (rst || gen_clr_b) begin
      rdy_b <= 1'b1; res_b <= '0; gerr_b <= 1'b0; gcnt_b <= 0;
    end else if (go_b) begin
      rdy_b <= 1'b0; gcnt_b <= 3;
    end else if (gcnt_b != 0) begin
      gcnt_b <= gcnt_b - 1;
      if (gcnt_b == 1) begin
        rdy_b <= 1'b1;
        if (next_prime(32'(res_b)) > MAXB) gerr_b <= 1'b1;
        else res_b <= 4'(next_prime(32'(res_b)));
      end
    end
  end

  // go pulse monitors
  int   go_cnt_a = 0, go_cnt_b = 0, go_dbl = 0;
  logic go_prev_a = 1'b0, go_prev_b = 1'b0;
  always @(posedge clk) begin
    go_prev_a <= go_a;
    go_prev_b <= go_b;
    if (go_a) go_cnt_a <= go_cnt_a + 1;
    if (go_b) go_cnt_b <= go_cnt_b + 1;
    if ((go_a && go_prev_a) || (go_b && go_prev_b)) go_dbl <= go_dbl + 1;
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected outcome of a stopping run, straight from the stop rules
  task automatic ref_expect(input int m, input int unsigned lim,
                            output int unsigned n, output int unsigned last);
    n = 0;
    last = 0;
    do begin
      last = next_prime(last);
      n++;
    end while ((m == 1) ? (n < lim) : (last < lim));
  endtask

  // Called at a negedge; returns at the negedge just after the start edge
  task automatic start_run_a(input logic [1:0] m, input int unsigned lim);
    mode_a = m; limit_a = 16'(lim); start_a = 1'b1; gen_clr_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; gen_clr_a = 1'b0; mode_a = '0; limit_a = '0;
  endtask

  task automatic start_run_b(input logic [1:0] m);
    mode_b = m; limit_b = '0; start_b = 1'b1; gen_clr_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0; gen_clr_b = 1'b0; mode_b = '0;
  endtask

  task automatic wait_idle(input bit sel_b, output bit ok);
    int n;
    n = 0;
    while ((sel_b ? busy_b : busy_a) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = sel_b ? !busy_b : !busy_a;
  endtask

  task automatic finish_a(input string tag, input int unsigned ecnt, input int unsigned elast,
                          input int gbase);
    bit ok;
    wait_idle(1'b0, ok);
    check({tag, "_ended"}, 64'(ok), 64'd1);
    check({tag, "_done"}, 64'(done_a), 64'd1);
    check({tag, "_err"}, 64'(err_a), 64'd0);
    check({tag, "_cnt"}, 64'(cnt_a), 64'(ecnt));
    check({tag, "_last"}, 64'(last_a), 64'(elast));
    check({tag, "_cycles"}, 64'(cyc_a), 64'(6 * ecnt));
    check({tag, "_gos"}, 64'(go_cnt_a - gbase), 64'(ecnt));
    check({tag, "_leds"}, 64'(leds_a), 64'd0);
  endtask

  task automatic finish_b_err(input string tag);
    bit ok;
    wait_idle(1'b1, ok);
    check({tag, "_ended"}, 64'(ok), 64'd1);
    check({tag, "_err"}, 64'(err_b), 64'd1);
    check({tag, "_done"}, 64'(done_b), 64'd0);
    check({tag, "_cnt"}, 64'(cnt_b), 64'd6);
    check({tag, "_last"}, 64'(last_b), 64'd13);
    check({tag, "_cycles_sat"}, 64'(cyc_b), 64'd15);
    repeat (8) @(negedge clk);
    check({tag, "_leds"}, 64'(leds_b), 64'b0111);
    check({tag, "_err_sticky"}, 64'(err_b), 64'd1);
  endtask

  typedef struct {
    int          mode;
    int unsigned limit;
    int unsigned exp_cnt;
    int unsigned exp_last;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          gbase;
    int unsigned ecnt, elast, lim;
    int          m;

    vecs[0] = '{1, 5, 5, 11};
    vecs[1] = '{2, 100, 26, 101};
    vecs[2] = '{1, 0, 1, 2};
    vecs[3] = '{2, 2, 1, 2};
    vecs[4] = '{2, 0, 1, 2};
    vecs[5] = '{2, 3, 2, 3};
    vecs[6] = '{2, 14, 7, 17};
    vecs[7] = '{1, 10, 10, 29};

    rst = 1'b1;
    start_a = 1'b0; mode_a = '0; limit_a = '0; gen_clr_a = 1'b0;
    start_b = 1'b0; mode_b = '0; limit_b = '0; gen_clr_b = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_go", 64'(go_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_err", 64'(err_a), 64'd0);
    check("rst_cnt", 64'(cnt_a), 64'd0);
    check("rst_last", 64'(last_a), 64'd0);
    check("rst_cycles", 64'(cyc_a), 64'd0);
    check("rst_leds", 64'(leds_a), 64'd0);
    check("rst_b_leds", 64'(leds_b), 64'd0);

    // Table of stopping runs
    foreach (vecs[i]) begin
      gbase = go_cnt_a;
      start_run_a(2'(vecs[i].mode), vecs[i].limit);
      check($sformatf("vec%0d_busy", i), 64'(busy_a), 64'd1);
      check($sformatf("vec%0d_done_clr", i), 64'(done_a), 64'd0);
      check($sformatf("vec%0d_cnt_clr", i), 64'(cnt_a), 64'd0);
      finish_a($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_last, gbase);
    end

    // Randomized stopping runs against the reference
    for (int r = 0; r < 12; r++) begin
      m   = int'($urandom_range(1, 2));
      lim = (m == 1) ? $urandom_range(0, 30) : $urandom_range(0, 150);
      ref_expect(m, lim, ecnt, elast);
      gbase = go_cnt_a;
      start_run_a(2'(m), lim);
      finish_a($sformatf("rnd%0d_m%0d_l%0d", r, m, lim), ecnt, elast, gbase);
    end

    // Start pulsed mid-run with different settings must be ignored
    gbase = go_cnt_a;
    start_run_a(2'd1, 5);
    repeat (3) @(negedge clk);
    mode_a = 2'd2; limit_a = 16'd3; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; mode_a = '0; limit_a = '0;
    finish_a("ign_start", 5, 11, gbase);

    // Start from DONE clears everything and begins a new run
    gbase = go_cnt_a;
    start_run_a(2'd2, 3);
    check("redo_done_clr", 64'(done_a), 64'd0);
    check("redo_last_clr", 64'(last_a), 64'd0);
    check("redo_cycles_clr", 64'(cyc_a), 64'd0);
    finish_a("redo", 2, 3, gbase);

    // Free-running 4-bit generator ends in overflow
    start_run_b(2'd0);
    finish_b_err("free0");
    start_run_b(2'd3);
    check("free3_leds_clr", 64'(leds_b), 64'd0);
    check("free3_err_clr", 64'(err_b), 64'd0);
    check("free3_cnt_clr", 64'(cnt_b), 64'd0);
    finish_b_err("free3");

    // Reset during WAIT
    start_run_a(2'd1, 5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_go", 64'(go_a), 64'd0);
    check("midrst_busy", 64'(busy_a), 64'd0);
    check("midrst_cnt", 64'(cnt_a), 64'd0);
    check("midrst_cycles", 64'(cyc_a), 64'd0);
    check("midrst_b_err", 64'(err_b), 64'd0);
    check("midrst_b_leds", 64'(leds_b), 64'd0);
    gbase = go_cnt_a;
    repeat (20) @(negedge clk);
    check("midrst_no_go", 64'(go_cnt_a - gbase), 64'd0);
    check("midrst_idle", 64'(busy_a), 64'd0);
    check("midrst_last", 64'(last_a), 64'd0);

    check("go_never_double", 64'(go_dbl), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
